// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer: state encoding and a width helper.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Ceiling log2, evaluated at elaboration time to size the bit counter.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: accepts an N-bit word over valid/ready and
// shifts it out MSB-first on a serial valid/ready stream with a last marker.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] input_signal,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         serial_last,
  input  logic         serial_ready,
  output logic         busy
);

  localparam int CW = clog2(N);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and serial_ready -> load_ready is
  // the single combinational path, which allows gapless back-to-back words.
  state_t        state;
  logic [N-1:0]  shift_reg;
  logic [CW-1:0] count;
  logic          load_acc;
  logic          bit_acc;

  assign serial_valid = (state == SHIFT);
  assign busy         = serial_valid;
  assign serial_out   = serial_valid & shift_reg[N-1];
  assign serial_last  = serial_valid && (count == '0);
  assign load_ready   = !reset && ((state == IDLE) || (serial_last && serial_ready));

  assign load_acc = load_valid && load_ready;
  assign bit_acc  = serial_valid && serial_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_acc) begin
            shift_reg <= input_signal;
            count     <= COUNT_LOAD;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_acc) begin
            if (count != '0) begin
              shift_reg <= {shift_reg[N-2:0], 1'b0};
              count     <= count - CW'(1);
            end else if (load_acc) begin
              // Last bit leaves while the next word arrives: no idle gap.
              shift_reg <= input_signal;
              count     <= COUNT_LOAD;
            end else begin
              shift_reg <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: directed scenarios and random traffic on an N=8
// instance against a bit-queue model, plus a directed word on the N=32 default.
module tb_word_serializer;

  logic clock;
  logic reset;

  // N = 8 instance
  logic [7:0] in8;
  logic       lv8, lr8, so8, sv8, sl8, sr8, busy8;

  // N = 32 instance
  logic [31:0] in32;
  logic        lv32, lr32, so32, sv32, sl32, sr32, busy32;

  int n_checks;
  int n_errors;

  // Scoreboard: bits still owed by the N=8 instance, front = bit on the wire.
  logic [0:0]  exp_q8[$];
  logic [31:0] tx_hist;

  word_serializer #(.N(8)) dut8 (
    .clock(clock), .reset(reset), .input_signal(in8), .load_valid(lv8),
    .load_ready(lr8), .serial_out(so8), .serial_valid(sv8), .serial_last(sl8),
    .serial_ready(sr8), .busy(busy8)
  );

  word_serializer dut32 (
    .clock(clock), .reset(reset), .input_signal(in32), .load_valid(lv32),
    .load_ready(lr32), .serial_out(so32), .serial_valid(sv32), .serial_last(sl32),
    .serial_ready(sr32), .busy(busy32)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle on the N=8 instance: drive, check outputs at negedge, advance model.
  task automatic step8(input logic lv, input logic [7:0] d, input logic sr);
    logic exp_rdy, exp_valid, exp_out, exp_last, bacc, lacc;
    lv8 = lv; in8 = d; sr8 = sr;
    @(negedge clock);
    exp_valid = (exp_q8.size() != 0);
    exp_out   = exp_valid ? exp_q8[0][0] : 1'b0;
    exp_last  = (exp_q8.size() == 1);
    exp_rdy   = (exp_q8.size() == 0) || (exp_q8.size() == 1 && sr);
    check("serial_valid", {31'b0, sv8}, {31'b0, exp_valid});
    check("serial_out", {31'b0, so8}, {31'b0, exp_out});
    check("serial_last", {31'b0, sl8}, {31'b0, exp_last});
    check("busy", {31'b0, busy8}, {31'b0, exp_valid});
    check("load_ready", {31'b0, lr8}, {31'b0, exp_rdy});
    bacc = exp_valid && sr;
    lacc = lv && exp_rdy;
    if (bacc) begin
      tx_hist = {tx_hist[30:0], exp_q8[0][0]};
      void'(exp_q8.pop_front());
    end
    if (lacc) begin
      for (int i = 7; i >= 0; i--) exp_q8.push_back(d[i]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle8(input int n);
    for (int i = 0; i < n; i++) step8(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    tx_hist  = '0;
    reset = 1'b1;
    lv8 = 1'b0; in8 = '0; sr8 = 1'b0;
    lv32 = 1'b0; in32 = '0; sr32 = 1'b0;

    // Reset state
    #2;
    check("rst_valid", {31'b0, sv8}, 32'd0);
    check("rst_out", {31'b0, so8}, 32'd0);
    check("rst_last", {31'b0, sl8}, 32'd0);
    check("rst_ready", {31'b0, lr8}, 32'd0);
    check("rst_busy32", {31'b0, busy32}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic word 8'hA5
    step8(1'b1, 8'hA5, 1'b1);
    idle8(9);
    check("basic_word", {24'b0, tx_hist[7:0]}, 32'h0000_00A5);

    // Backpressure 8'hC3: 2 bits, 3 stalled cycles, 6 bits = 11 cycles
    step8(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 2; i++) step8(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step8(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step8(1'b0, 8'h00, 1'b1);
    check("bp_len", {31'b0, sv8}, 32'd0);
    idle8(1);
    check("bp_word", {24'b0, tx_hist[7:0]}, 32'h0000_00C3);

    // Back-to-back FF then 00 with load_valid held
    step8(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) step8(1'b1, 8'h00, 1'b1);
    idle8(9);
    check("b2b_words", {16'b0, tx_hist[15:0]}, 32'h0000_FF00);

    // Ignored load while busy
    step8(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) step8(1'b0, 8'h00, 1'b1);
    step8(1'b1, 8'h11, 1'b1);
    idle8(6);
    check("ignored_load", {24'b0, tx_hist[7:0]}, 32'h0000_003C);

    // Reset mid-word after 3 bits, with a load attempt during reset
    step8(1'b1, 8'hE7, 1'b1);
    for (int i = 0; i < 3; i++) step8(1'b0, 8'h00, 1'b1);
    lv8 = 1'b1; in8 = 8'h77;
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'b0, sv8}, 32'd0);
    check("midrst_out", {31'b0, so8}, 32'd0);
    check("midrst_busy", {31'b0, busy8}, 32'd0);
    check("midrst_ready", {31'b0, lr8}, 32'd0);
    exp_q8.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    lv8 = 1'b0;
    step8(1'b0, 8'h00, 1'b1);
    step8(1'b1, 8'h5A, 1'b1);
    idle8(9);
    check("post_rst_word", {24'b0, tx_hist[7:0]}, 32'h0000_005A);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step8(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    idle8(10);

    // Default width: 32'h8000_0001
    lv32 = 1'b1; in32 = 32'h8000_0001; sr32 = 1'b1;
    @(negedge clock);
    check("w32_ready", {31'b0, lr32}, 32'd1);
    @(posedge clock);
    #1 lv32 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      check("w32_valid", {31'b0, sv32}, 32'd1);
      check("w32_out", {31'b0, so32}, (i == 0 || i == 31) ? 32'd1 : 32'd0);
      check("w32_last", {31'b0, sl32}, (i == 31) ? 32'd1 : 32'd0);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("w32_done", {31'b0, sv32}, 32'd0);
    check("w32_ready_end", {31'b0, lr32}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial transmitter for N-bit words: it accepts one word over a valid/ready load handshake and shifts it out MSB-first, one bit per accepted cycle, on a serial valid/ready stream. It is the sending end of the parallel word-register path. A word captured in parallel upstream leaves this block as a bit stream toward a serial receiver or a test sink. It uses a single clock domain.

## Interface
- N, default 32, word width in bits; legal range N >= 2.
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- input_signal  input  N  word to transmit; sampled only on an accepted load.
- load_valid  input  1  upstream presents a word on input_signal.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current bit, MSB first.
- serial_valid  output  1  serial_out carries a word bit.
- serial_last  output  1  current bit is bit 0 of the word, i.e. the last bit.
- serial_ready  input  1  downstream consumes the current bit at this edge.
- busy  output  1  a word is in flight (state SHIFT).

## Operation
- State register: IDLE or SHIFT. Datapath registers: shift_reg[N-1:0] and count[$clog2(N)-1:0].
- Reset values (asserted or released):
  - state = IDLE, shift_reg = 0, count = 0.
  - serial_out = 0, serial_valid = 0, serial_last = 0, busy = 0.
  - load_ready = 0 while reset is high; 1 after release.
- Load acceptance = load_valid && load_ready.
- Bit acceptance = serial_valid && serial_ready.
- Outputs are decoded from registered state only:
  - serial_valid = (state == SHIFT); busy is the same signal.
  - serial_out = shift_reg[N-1] when serial_valid, else 0.
  - serial_last = serial_valid && (count == 0).
  - load_ready = !reset && (state == IDLE || (serial_last && serial_ready)). This is the only combinational path from serial_ready to load_ready.
- IDLE, on load acceptance: shift_reg <= input_signal, count <= N-1, state goes to SHIFT.
- SHIFT, on bit acceptance with count != 0: shift_reg <= {shift_reg[N-2:0], 1'b0}, count <= count-1.
- SHIFT, on bit acceptance with count == 0:
  - With a simultaneous load acceptance (back-to-back): reload shift_reg and count as in IDLE and stay in SHIFT.
  - Otherwise: state goes to IDLE and shift_reg <= 0.
- SHIFT, serial_ready low: all registers hold. serial_out, serial_valid and serial_last stay stable (backpressure).
- load_valid while load_ready is low is ignored. input_signal is not sampled, and nothing is queued.

## Timing
- A load accepted at edge k puts the MSB on serial_out in the cycle after k, i.e. visible after k.
- With serial_ready held high, bits N-1..0 appear in N consecutive cycles. serial_last is high in the Nth cycle.
- Idle gap between words:
  - Back-to-back (load_valid high during the last bit): zero cycles; the MSB of the next word follows bit 0 directly.
  - Otherwise: at least one cycle of serial_valid = 0.
- Throughput: 1 bit/cycle maximum; one word per N cycles sustained.
- Reset mid-word: the word is discarded and outputs go to reset values asynchronously. The first load after release behaves as from IDLE.
- Reset and load_valid in the same cycle: no load (load_ready = 0).
- count wraps never; the transition at count == 0 always leaves SHIFT or reloads.

## Structure
- Shared package serializer_pkg holds:
  - State encoding constants: IDLE = 1'b0, SHIFT = 1'b1.
  - A clog2 helper function, used for the count width.
- No sub-module needed. The shift register, down-counter and two-state FSM live in one module.

## Test plan
- Reset check, N=8: assert reset mid-SHIFT after 3 bits -> serial_valid = 0, serial_out = 0, busy = 0 immediately; after release load_ready = 1; next word 8'h5A emits 0,1,0,1,1,0,1,0.
- Basic word, N=8: load 8'hA5, serial_ready = 1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; serial_last only on the 8th; then serial_valid = 0 and load_ready = 1.
- Backpressure, N=8: load 8'hC3; drop serial_ready for 3 cycles after bit 2 -> serial_out and serial_last frozen during the stall; the full sequence 1,1,0,0,0,0,1,1 is still delivered, in 11 cycles.
- Back-to-back, N=8: 8'hFF then 8'h00, load_valid held -> 16 contiguous valid cycles, 8 ones then 8 zeros; serial_last on cycles 8 and 16; load_ready high only in the cycle of bit 0.
- Ignored load, N=8: pulse load_valid with 8'h11 while busy mid-word -> 8'h11 is never transmitted; the current word completes unchanged.
- Default width, N=32: load 32'h8000_0001 -> 1, then 30 zeros, then 1 with serial_last high on cycle 32.
